// File: rtl/clic_pkg.sv
// Shared types and ordering function for the CLIC interrupt arbiter.
package clic_pkg;

    localparam int CLIC_LEVEL_W = 8;
    localparam int CLIC_ID_W    = 10;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        HOLD
    } clic_arb_state_e;

    typedef struct packed {
        logic                    valid;
        logic [1:0]              priv;
        logic [CLIC_LEVEL_W-1:0] level;
        logic [CLIC_ID_W-1:0]    id;
    } clic_arb_entry_t;

    // Ordering: valid first, then higher priv, higher level, higher id.
    function automatic logic clic_better(input clic_arb_entry_t a, input clic_arb_entry_t b);
        if (!a.valid) return 1'b0;
        if (!b.valid) return 1'b1;
        if (a.priv != b.priv) return a.priv > b.priv;
        if (a.level != b.level) return a.level > b.level;
        return a.id > b.id;
    endfunction

    // Reserved encoding 2'b10 ranks and reports as supervisor.
    function automatic logic [1:0] clic_norm_priv(input logic [1:0] p);
        return (p == 2'b10) ? 2'b01 : p;
    endfunction

endpackage

// File: rtl/clic_max_tree.sv
// Balanced combinational max-reduction over arbitration entries.
module clic_max_tree
    import clic_pkg::*;
#(
    parameter int N = 64
) (
    input  clic_arb_entry_t [N-1:0] leaf,
    output clic_arb_entry_t         win
);

    localparam int Levels = $clog2(N);

    for (genvar s = 0; s <= Levels; s++) begin : g_stage
        clic_arb_entry_t [(N >> s)-1:0] v;
        if (s == 0) begin : g_leaf
            assign v = leaf;
        end else begin : g_node
            for (genvar k = 0; k < (N >> s); k++) begin : g_cmp
                assign v[k] = clic_better(g_stage[s-1].v[2*k+1], g_stage[s-1].v[2*k])
                            ? g_stage[s-1].v[2*k+1] : g_stage[s-1].v[2*k];
            end
        end
    end

    assign win = g_stage[Levels].v[0];

endmodule

// File: rtl/clic_irq_arbiter.sv
// CLIC-to-core interrupt arbiter: offers the best pending source, holds until acked.
// Optional macro CLIC_ARB_PIPE_EN adds a register after the comparison tree.
//
// state | meaning
// IDLE  | nothing offered, arbitrating
// OFFER | winner presented on irq_o, re-arbitrated every cycle
// HOLD  | outputs forced idle after an ack while the core consumes it
module clic_irq_arbiter
    import clic_pkg::*;
#(
    parameter int NumSrc     = 64,
    parameter int HoldCycles = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumSrc-1:0]           src_pend_i,
    input  logic [NumSrc-1:0]           src_ie_i,
    input  logic [NumSrc-1:0]           src_edge_i,
    input  logic [NumSrc*8-1:0]         src_level_i,
    input  logic [NumSrc*2-1:0]         src_priv_i,
    output logic [NumSrc-1:0]           irq_o,
    output logic [7:0]                  irq_level_o,
    output logic [1:0]                  irq_priv_o,
    input  logic                        irq_ack_i,
    input  logic [$clog2(NumSrc)-1:0]   irq_ack_id_i,
    output logic [NumSrc-1:0]           src_clr_o
);

    localparam int CntW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;

    clic_arb_entry_t [NumSrc-1:0] leaf;
    clic_arb_entry_t              win;
    clic_arb_entry_t              cand;
    clic_arb_state_e              state;
    logic [CntW-1:0]              hold_cnt;
    logic [CLIC_ID_W-1:0]         cur_id;
    logic [NumSrc-1:0]            cand_onehot;
    logic                         ack_hit;

    for (genvar i = 0; i < NumSrc; i++) begin : g_leaf
        assign leaf[i].valid = src_pend_i[i] & src_ie_i[i] & (src_level_i[8*i +: 8] != 8'd0);
        assign leaf[i].priv  = clic_norm_priv(src_priv_i[2*i +: 2]);
        assign leaf[i].level = src_level_i[8*i +: 8];
        assign leaf[i].id    = CLIC_ID_W'(i);
    end

    clic_max_tree #(.N(NumSrc)) u_tree (
        .leaf (leaf),
        .win  (win)
    );

`ifdef CLIC_ARB_PIPE_EN
    clic_arb_entry_t win_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) win_q <= '0;
        else       win_q <= win;
    end

    assign cand = win_q;
`else
    assign cand = win;
`endif

    assign cand_onehot = {{(NumSrc-1){1'b0}}, 1'b1} << cand.id;
    // Ack is matched against what the core actually sees, not the fresh winner.
    assign ack_hit     = irq_ack_i && (CLIC_ID_W'(irq_ack_id_i) == cur_id);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            cur_id      <= '0;
            irq_o       <= '0;
            irq_level_o <= '0;
            irq_priv_o  <= '0;
            src_clr_o   <= '0;
        end else begin
            src_clr_o <= '0;
            case (state)
                IDLE: begin
                    if (cand.valid) begin
                        irq_o       <= cand_onehot;
                        irq_level_o <= cand.level;
                        irq_priv_o  <= cand.priv;
                        cur_id      <= cand.id;
                        state       <= OFFER;
                    end
                end
                OFFER: begin
                    if (ack_hit) begin
                        irq_o       <= '0;
                        irq_level_o <= '0;
                        irq_priv_o  <= '0;
                        src_clr_o   <= irq_o & src_edge_i;
                        hold_cnt    <= CntW'(HoldCycles - 1);
                        state       <= HOLD;
                    end else if (cand.valid) begin
                        irq_o       <= cand_onehot;
                        irq_level_o <= cand.level;
                        irq_priv_o  <= cand.priv;
                        cur_id      <= cand.id;
                    end else begin
                        irq_o       <= '0;
                        irq_level_o <= '0;
                        irq_priv_o  <= '0;
                        state       <= IDLE;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) state <= IDLE;
                    else                hold_cnt <= hold_cnt - CntW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
